// File: rtl/cv32e40p_tmr_voter_monitor_pkg.sv
// Shared types for the triplicated-unit voter: operating modes and the
// event replica code used when no single replica can be blamed.
package cv32e40p_tmr_voter_monitor_pkg;

    typedef enum logic [1:0] {
        TMR_MODE_FULL = 2'b00,
        TMR_MODE_DUAL = 2'b01,
        TMR_MODE_FAIL = 2'b10
    } tmr_mode_e;

    localparam logic [1:0] TMR_EVT_MULTI = 2'd3;

endpackage

// File: rtl/cv32e40p_tmr_voter_monitor_err_counter.sv
// Saturating up/down disagreement counter for one replica; at_threshold
// flags that the value after this edge equals THRESHOLD.
module cv32e40p_tmr_err_counter #(
    parameter int unsigned THRESHOLD = 4,
    parameter int unsigned CW        = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          at_threshold
);

    localparam logic [CW-1:0] MAX = CW'(THRESHOLD);

    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc) begin
            if (cnt != MAX) cnt_nxt = cnt + 1'b1;
        end else if (dec) begin
            if (cnt != '0) cnt_nxt = cnt - 1'b1;
        end
    end

    assign at_threshold = (cnt_nxt == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_nxt;
    end

endmodule

// File: rtl/cv32e40p_tmr_voter_monitor.sv
// Stateful TMR voter: bitwise vote, per-replica leaky error counters,
// TMR -> DMR -> FAIL degradation and a single-entry mode-change event.
module cv32e40p_tmr_voter_monitor
    import cv32e40p_tmr_voter_monitor_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned ERR_THRESHOLD = 4,
    parameter int unsigned LEAK_PERIOD   = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   valid_i,
    input  logic [WIDTH-1:0]                       res0_i,
    input  logic [WIDTH-1:0]                       res1_i,
    input  logic [WIDTH-1:0]                       res2_i,
    input  logic                                   clear_i,
    output logic [WIDTH-1:0]                       result_o,
    output logic                                   result_valid_o,
    output logic                                   mismatch_o,
    output logic                                   uncorrectable_o,
    output tmr_mode_e                              mode_o,
    output logic [2:0]                             replica_en_o,
    output logic [3*$clog2(ERR_THRESHOLD+1)-1:0]   err_cnt_o,
    output logic                                   evt_valid_o,
    input  logic                                   evt_ready_i,
    output tmr_mode_e                              evt_mode_o,
    output logic [1:0]                             evt_replica_o,
    output logic                                   evt_overflow_o
);

    localparam int unsigned CW = $clog2(ERR_THRESHOLD + 1);
    localparam int unsigned LW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam logic [LW-1:0] LEAK_LAST = LW'((LEAK_PERIOD > 0) ? LEAK_PERIOD - 1 : 0);

    logic [WIDTH-1:0] res [3];
    logic [WIDTH-1:0] maj, sel, voted;
    logic [2:0]       dis, inc, dec, at_thr;
    logic [1:0]       n_dis, iso_idx;
    logic             go_dual, go_fail, evt_load;
    logic [LW-1:0]    leak_cnt;
    logic [CW-1:0]    cnt [3];

    assign res[0] = res0_i;
    assign res[1] = res1_i;
    assign res[2] = res2_i;

    // Vote path: majority in FULL, lowest surviving replica once degraded.
    always_comb begin
        maj = (res0_i & res1_i) | (res1_i & res2_i) | (res0_i & res2_i);
        if (replica_en_o[0])      sel = res0_i;
        else if (replica_en_o[1]) sel = res1_i;
        else                      sel = res2_i;
        voted = (mode_o == TMR_MODE_FULL) ? maj : sel;
        for (int k = 0; k < 3; k++) dis[k] = replica_en_o[k] && (res[k] != voted);
        n_dis = 2'(dis[0]) + 2'(dis[1]) + 2'(dis[2]);
    end

    assign result_o       = valid_i ? voted : '0;
    assign result_valid_o = valid_i;
    assign mismatch_o     = valid_i && (dis != 3'b000);

    always_comb begin
        inc = 3'b000;
        dec = 3'b000;
        if (valid_i && mode_o == TMR_MODE_FULL) begin
            if (n_dis == 2'd1) inc = dis;
            // Leak only on clean cycles, so it never meets an increment.
            if (LEAK_PERIOD != 0 && n_dis == 2'd0 && leak_cnt == LEAK_LAST) dec = 3'b111;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_cnt
        cv32e40p_tmr_err_counter #(
            .THRESHOLD (ERR_THRESHOLD),
            .CW        (CW)
        ) u_cnt (
            .clk          (clk),
            .rst_n        (rst_n),
            .inc          (inc[g]),
            .dec          (dec[g]),
            .clr          (clear_i),
            .cnt          (cnt[g]),
            .at_threshold (at_thr[g])
        );
        assign err_cnt_o[g*CW +: CW] = cnt[g];
    end

    always_comb begin
        go_dual         = 1'b0;
        go_fail         = 1'b0;
        iso_idx         = 2'd0;
        uncorrectable_o = 1'b0;
        if (valid_i) begin
            case (mode_o)
                TMR_MODE_FULL: begin
                    if (n_dis >= 2'd2) begin
                        uncorrectable_o = 1'b1;
                        go_fail         = 1'b1;
                    end else begin
                        for (int k = 0; k < 3; k++) begin
                            if (inc[k] && at_thr[k]) begin
                                go_dual = 1'b1;
                                iso_idx = 2'(k);
                            end
                        end
                    end
                end
                TMR_MODE_DUAL: begin
                    if (dis != 3'b000) begin
                        uncorrectable_o = 1'b1;
                        go_fail         = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign evt_load = valid_i && !clear_i && (go_dual || go_fail);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_o       <= TMR_MODE_FULL;
            replica_en_o <= 3'b111;
            leak_cnt     <= '0;
        end else if (clear_i) begin
            mode_o       <= TMR_MODE_FULL;
            replica_en_o <= 3'b111;
            leak_cnt     <= '0;
        end else if (valid_i) begin
            if (go_fail) begin
                mode_o <= TMR_MODE_FAIL;
            end else if (go_dual) begin
                mode_o       <= TMR_MODE_DUAL;
                replica_en_o <= replica_en_o & ~dis;
            end
            if (mode_o == TMR_MODE_FULL && LEAK_PERIOD != 0) begin
                if (n_dis != 2'd0 || leak_cnt == LEAK_LAST) leak_cnt <= '0;
                else                                        leak_cnt <= leak_cnt + 1'b1;
            end
        end
    end

    // Event register: a new event always wins; losing an unread one is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid_o    <= 1'b0;
            evt_mode_o     <= TMR_MODE_FULL;
            evt_replica_o  <= 2'd0;
            evt_overflow_o <= 1'b0;
        end else begin
            if (evt_load) begin
                evt_valid_o   <= 1'b1;
                evt_mode_o    <= go_fail ? TMR_MODE_FAIL : TMR_MODE_DUAL;
                evt_replica_o <= go_fail ? TMR_EVT_MULTI : iso_idx;
                if (evt_valid_o && !evt_ready_i) evt_overflow_o <= 1'b1;
            end else if (evt_valid_o && evt_ready_i) begin
                evt_valid_o <= 1'b0;
            end
            if (clear_i) evt_overflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cv32e40p_tmr_voter_monitor.sv
// Directed bench for the TMR voter/monitor with hand-computed expectations.
module tb_cv32e40p_tmr_voter_monitor;
    import cv32e40p_tmr_voter_monitor_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] res0_i = '0, res1_i = '0, res2_i = '0;
    logic        clear_i = 1'b0;
    logic        evt_ready_i = 1'b0;
    logic [31:0] result_o;
    logic        result_valid_o, mismatch_o, uncorrectable_o;
    tmr_mode_e   mode_o, evt_mode_o;
    logic [2:0]  replica_en_o;
    logic [8:0]  err_cnt_o;
    logic        evt_valid_o, evt_overflow_o;
    logic [1:0]  evt_replica_o;

    int checks = 0;
    int failures = 0;

    cv32e40p_tmr_voter_monitor #(
        .WIDTH         (32),
        .ERR_THRESHOLD (4),
        .LEAK_PERIOD   (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_i         (valid_i),
        .res0_i          (res0_i),
        .res1_i          (res1_i),
        .res2_i          (res2_i),
        .clear_i         (clear_i),
        .result_o        (result_o),
        .result_valid_o  (result_valid_o),
        .mismatch_o      (mismatch_o),
        .uncorrectable_o (uncorrectable_o),
        .mode_o          (mode_o),
        .replica_en_o    (replica_en_o),
        .err_cnt_o       (err_cnt_o),
        .evt_valid_o     (evt_valid_o),
        .evt_ready_i     (evt_ready_i),
        .evt_mode_o      (evt_mode_o),
        .evt_replica_o   (evt_replica_o),
        .evt_overflow_o  (evt_overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        valid_i = v;
        res0_i  = a;
        res1_i  = b;
        res2_i  = c;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #10;
        chk("rst_mode", 32'(mode_o), 32'(TMR_MODE_FULL));
        chk("rst_en", 32'(replica_en_o), 32'h7);
        chk("rst_cnt", 32'(err_cnt_o), 32'h0);
        chk("rst_evt_valid", 32'(evt_valid_o), 32'h0);
        chk("rst_evt_mode", 32'(evt_mode_o), 32'h0);
        chk("rst_evt_rep", 32'(evt_replica_o), 32'h0);
        chk("rst_ovf", 32'(evt_overflow_o), 32'h0);
        tick();
        rst_n = 1'b1;

        // valid low: outputs gated, no counting
        drive(1'b0, 32'h1, 32'h2, 32'h4);
        #1;
        chk("idle_result", result_o, 32'h0);
        chk("idle_mismatch", 32'(mismatch_o), 32'h0);
        chk("idle_unc", 32'(uncorrectable_o), 32'h0);
        tick();
        chk("idle_mode", 32'(mode_o), 32'(TMR_MODE_FULL));

        drive(1'b1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
        #1;
        chk("eq_result", result_o, 32'h1234_5678);
        chk("eq_rvalid", 32'(result_valid_o), 32'h1);
        chk("eq_mismatch", 32'(mismatch_o), 32'h0);
        tick();
        chk("eq_cnt", 32'(err_cnt_o), 32'h0);

        // replica 1 disagrees four times -> isolated
        drive(1'b1, 32'h0, 32'hFFFF_0000, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("r1_result", result_o, 32'h0);
            chk("r1_mismatch", 32'(mismatch_o), 32'h1);
            chk("r1_unc", 32'(uncorrectable_o), 32'h0);
            tick();
            chk("r1_cnt1", 32'(err_cnt_o[5:3]), 32'(i));
        end
        chk("dual_mode", 32'(mode_o), 32'(TMR_MODE_DUAL));
        chk("dual_en", 32'(replica_en_o), 32'h5);
        chk("dual_evt_valid", 32'(evt_valid_o), 32'h1);
        chk("dual_evt_mode", 32'(evt_mode_o), 32'(TMR_MODE_DUAL));
        chk("dual_evt_rep", 32'(evt_replica_o), 32'h1);

        drive(1'b1, 32'h5, 32'h0, 32'h6);
        #1;
        chk("dual_unc", 32'(uncorrectable_o), 32'h1);
        chk("dual_result", result_o, 32'h5);
        tick();
        chk("fail_mode", 32'(mode_o), 32'(TMR_MODE_FAIL));
        chk("fail_evt_mode", 32'(evt_mode_o), 32'(TMR_MODE_FAIL));
        chk("fail_evt_rep", 32'(evt_replica_o), 32'(TMR_EVT_MULTI));
        chk("fail_ovf", 32'(evt_overflow_o), 32'h1);
        chk("fail_en", 32'(replica_en_o), 32'h5);
        chk("fail_cnt1", 32'(err_cnt_o[5:3]), 32'h4);
        #1;
        chk("fail_result", result_o, 32'h5);
        chk("fail_mismatch", 32'(mismatch_o), 32'h1);

        drive(1'b0, 32'h0, 32'h0, 32'h0);
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;
        chk("ack_evt_valid", 32'(evt_valid_o), 32'h0);
        chk("ack_ovf_sticky", 32'(evt_overflow_o), 32'h1);
        chk("ack_mode", 32'(mode_o), 32'(TMR_MODE_FAIL));

        // clear in FAIL with valid mismatching data
        drive(1'b1, 32'h1, 32'h2, 32'h4);
        clear_i = 1'b1;
        #1;
        chk("clr_result", result_o, 32'h1);
        tick();
        clear_i = 1'b0;
        chk("clr_mode", 32'(mode_o), 32'(TMR_MODE_FULL));
        chk("clr_en", 32'(replica_en_o), 32'h7);
        chk("clr_cnt", 32'(err_cnt_o), 32'h0);
        chk("clr_ovf", 32'(evt_overflow_o), 32'h0);

        // leak: period 2, mismatch restarts the clean run
        drive(1'b1, 32'h0, 32'h0, 32'h3);
        tick();
        chk("leak_cnt2_a", 32'(err_cnt_o[8:6]), 32'h1);
        drive(1'b1, 32'h0, 32'h0, 32'h0);
        tick();
        chk("leak_cnt2_b", 32'(err_cnt_o[8:6]), 32'h1);
        drive(1'b1, 32'h0, 32'h0, 32'h3);
        tick();
        chk("leak_cnt2_c", 32'(err_cnt_o[8:6]), 32'h2);
        drive(1'b1, 32'h0, 32'h0, 32'h0);
        tick();
        chk("leak_restart", 32'(err_cnt_o[8:6]), 32'h2);
        tick();
        chk("leak_dec1", 32'(err_cnt_o[8:6]), 32'h1);
        tick();
        tick();
        chk("leak_dec0", 32'(err_cnt_o[8:6]), 32'h0);

        // two replicas disagree with the vote
        drive(1'b1, 32'h0F, 32'hF0, 32'h00);
        #1;
        chk("multi_result", result_o, 32'h0);
        chk("multi_unc", 32'(uncorrectable_o), 32'h1);
        tick();
        chk("multi_mode", 32'(mode_o), 32'(TMR_MODE_FAIL));
        chk("multi_evt_rep", 32'(evt_replica_o), 32'(TMR_EVT_MULTI));
        chk("multi_evt_valid", 32'(evt_valid_o), 32'h1);
        chk("multi_ovf", 32'(evt_overflow_o), 32'h0);
        chk("multi_cnt", 32'(err_cnt_o), 32'h0);

        drive(1'b0, 32'h0, 32'h0, 32'h0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr2_mode", 32'(mode_o), 32'(TMR_MODE_FULL));
        chk("clr2_evt_kept", 32'(evt_valid_o), 32'h1);

        // reach DUAL via replica 0, then async reset mid-cycle
        drive(1'b1, 32'h9, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_mode", 32'(mode_o), 32'(TMR_MODE_DUAL));
        chk("pre_rst_en", 32'(replica_en_o), 32'h6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mode", 32'(mode_o), 32'(TMR_MODE_FULL));
        chk("arst_en", 32'(replica_en_o), 32'h7);
        chk("arst_cnt", 32'(err_cnt_o), 32'h0);
        chk("arst_evt_valid", 32'(evt_valid_o), 32'h0);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
